// File: rtl/alu_exec_stage.sv
// LEGv8 execute stage: decodes a 4-bit aluControl code and registers the result behind a
// 2-entry skid buffer. Optional NZCV flag output is enabled by defining ALU_FLAGS_EN.
module alu_exec_stage #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              br_taken,
  output logic              illegal_op,
`ifdef ALU_FLAGS_EN
  output logic [3:0]        flags_nzcv,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a beat moves on a rising edge where valid & ready are both high; a
  // producer holding valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_MOVE = 4'b1101;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_CBNZ = 4'b1111;

  typedef struct packed {
`ifdef ALU_FLAGS_EN
    logic [3:0]        nzcv;
`endif
    logic              br;
    logic              zero;
    logic [DATA_W-1:0] res;
  } entry_t;

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   illegal_q, illegal_d;
  entry_t out_q, out_d, skid_q, skid_d;
  entry_t alu_e;
  logic   alu_ill;
  logic   accept, transfer;
  logic [DATA_W-1:0] add_r, sub_r;

`ifdef ALU_FLAGS_EN
  logic [DATA_W:0] add_w, sub_w;
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  // Two's-complement subtract keeps carry-out meaning "no borrow".
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
  assign add_r = add_w[DATA_W-1:0];
  assign sub_r = sub_w[DATA_W-1:0];
`else
  assign add_r = op_a + op_b;
  assign sub_r = op_a - op_b;
`endif

  always_comb begin
    alu_e   = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_e.res = add_r;
      OP_SUB:  alu_e.res = sub_r;
      OP_AND:  alu_e.res = op_a & op_b;
      OP_ORR:  alu_e.res = op_a | op_b;
      OP_EOR:  alu_e.res = op_a ^ op_b;
      OP_MOVE: alu_e.res = op_b;
      OP_CBZ:  begin alu_e.res = op_b; alu_e.br = (op_b == '0); end
      OP_CBNZ: begin alu_e.res = op_b; alu_e.br = (op_b != '0); end
      default: alu_ill = 1'b1;
    endcase
    alu_e.zero = (alu_e.res == '0);
`ifdef ALU_FLAGS_EN
    alu_e.nzcv[3] = alu_e.res[DATA_W-1];
    alu_e.nzcv[2] = alu_e.zero;
    if (alu_ctrl == OP_ADD) begin
      alu_e.nzcv[1] = add_w[DATA_W];
      alu_e.nzcv[0] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                      (add_r[DATA_W-1] != op_a[DATA_W-1]);
    end else if (alu_ctrl == OP_SUB) begin
      alu_e.nzcv[1] = sub_w[DATA_W];
      alu_e.nzcv[0] = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                      (sub_r[DATA_W-1] != op_a[DATA_W-1]);
    end
`endif
  end

  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign transfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: if (accept) begin state_d = S_ONE; out_d = alu_e; end
      S_ONE: begin
        if (accept && !transfer) begin
          state_d = S_TWO;
          skid_d  = alu_e;
        end else if (transfer && !accept) begin
          state_d = S_EMPTY;
        end else if (transfer && accept) begin
          out_d = alu_e;
        end
      end
      S_TWO: if (transfer) begin state_d = S_ONE; out_d = skid_q; end
      default: state_d = S_EMPTY;
    endcase
    in_ready_d = (state_d != S_TWO);
    illegal_d  = illegal_q | (accept & alu_ill);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      illegal_q  <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      illegal_q  <= illegal_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign result     = out_q.res;
  assign zero       = out_q.zero;
  assign br_taken   = out_q.br;
  assign illegal_op = illegal_q;
  assign dbg_state  = state_q;
`ifdef ALU_FLAGS_EN
  assign flags_nzcv = out_q.nzcv;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU ops, skid-buffer backpressure, sticky illegal flag
// and asynchronous reset while full.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [63:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero, br_taken, illegal_op;
  logic [1:0]  dbg_state;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags_nzcv;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .br_taken   (br_taken),
    .illegal_op (illegal_op),
`ifdef ALU_FLAGS_EN
    .flags_nzcv (flags_nzcv),
`endif
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One op into an empty stage; returns on the next falling edge with the op on the outputs.
  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] r, input logic z, input logic br);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, z});
    chk({tag, "_br"}, {63'd0, br_taken}, {63'd0, br});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);
    chk("rst_br", {63'd0, br_taken}, 64'd0);
    chk("rst_illegal", {63'd0, illegal_op}, 64'd0);
    rst = 1'b0;

    issue(4'b0010, 64'd5, 64'd7);
    chk_out("add", 64'd12, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("add_flags", {60'd0, flags_nzcv}, 64'h0);
`endif
    @(negedge clk);
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    issue(4'b1010, 64'd7, 64'd7);
    chk_out("sub_eq", 64'd0, 1'b1, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("sub_eq_flags", {60'd0, flags_nzcv}, 64'h6);
`endif
    issue(4'b1010, 64'd0, 64'd1);
    chk_out("sub_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("sub_wrap_flags", {60'd0, flags_nzcv}, 64'h8);
`endif
    issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_out("add_wrap", 64'd0, 1'b1, 1'b0);
    issue(4'b0110, 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000);
    chk_out("and", 64'h0F00_0F00_1234_0000, 1'b0, 1'b0);
    issue(4'b0100, 64'h00F0, 64'h0F00);
    chk_out("orr", 64'h0FF0, 1'b0, 1'b0);
    issue(4'b1001, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000);
    chk_out("eor", 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    issue(4'b1101, 64'd99, 64'h1234);
    chk_out("move", 64'h1234, 1'b0, 1'b0);
    issue(4'b0111, 64'd3, 64'd0);
    chk_out("cbz_0", 64'd0, 1'b1, 1'b1);
    issue(4'b0111, 64'd3, 64'd9);
    chk_out("cbz_9", 64'd9, 1'b0, 1'b0);
    issue(4'b1111, 64'd3, 64'd0);
    chk_out("cbnz_0", 64'd0, 1'b1, 1'b0);
    issue(4'b1111, 64'd3, 64'd5);
    chk_out("cbnz_5", 64'd5, 1'b0, 1'b1);
    chk("legal_no_illegal", {63'd0, illegal_op}, 64'd0);

    // Backpressure: two ops fill output reg and skid, third is refused.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 64'd1; op_b = 64'd1;
    @(negedge clk);
    chk("stall1_in_ready", {63'd0, in_ready}, 64'd1);
    chk("stall1_result", result, 64'd2);
    alu_ctrl = 4'b0100; op_a = 64'hF0; op_b = 64'h0F;
    @(negedge clk);
    chk("stall2_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall2_state", {62'd0, dbg_state}, 64'd2);
    chk("stall2_result", result, 64'd2);
    alu_ctrl = 4'b0010; op_a = 64'd100; op_b = 64'd1;
    @(negedge clk);
    chk("stall3_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall3_hold", result, 64'd2);
    chk("stall3_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_out("fifo_second", 64'hFF, 1'b0, 1'b0);
    chk("fifo_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("fifo_no_third", {63'd0, out_valid}, 64'd0);

    issue(4'b0000, 64'd5, 64'd6);
    chk_out("illegal0", 64'd0, 1'b1, 1'b0);
    chk("illegal0_flag", {63'd0, illegal_op}, 64'd1);
    issue(4'b0010, 64'd1, 64'd2);
    chk_out("after_illegal", 64'd3, 1'b0, 1'b0);
    chk("illegal_sticky", {63'd0, illegal_op}, 64'd1);
    issue(4'b0011, 64'd8, 64'd8);
    chk_out("illegal3", 64'd0, 1'b1, 1'b0);

    // Fill both entries, then reset asynchronously between clock edges.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 64'd3; op_b = 64'd4;
    @(negedge clk);
    alu_ctrl = 4'b1010; op_a = 64'd9; op_b = 64'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_state", {62'd0, dbg_state}, 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_result", result, 64'd0);
    chk("arst_illegal", {63'd0, illegal_op}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
    end
    issue(4'b0010, 64'd20, 64'd22);
    chk_out("post_rst_add", 64'd42, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
